fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Fetch-stage controller that sequences the program counter into `instruction_block` and hands fetched words to decode. It owns the PC register and drives `instruction_block.pc`. It latches `instruction_block.instruction` into an instruction register, presented to decode through a valid/ready handshake. It also applies branch/jump redirects with a pipeline flush and stops fetching on a halt word.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address; always word-aligned.
- `HALT_WORD`, 32'hFC00_0000: instruction encoding that terminates fetch.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; begins fetching when sampled high in IDLE.
- `imem_addr`  out  32  to `instruction_block.pc`; equals the PC register.
- `imem_data`  in  32  from `instruction_block.instruction`; combinational from `imem_addr`, same cycle.
- `ir`  out  32  latched instruction.
- `ir_pc`  out  32  address `ir` was fetched from.
- `ir_valid`  out  1  `ir`/`ir_pc` hold a live instruction.
- `ir_ready`  in  1  decode accepts `ir` this cycle.
- `redirect`  in  1  branch/jump taken; one-cycle pulse.
- `redirect_pc`  in  32  target address; bits [1:0] ignored (forced to 0).
- `halted`  out  1  fetch permanently stopped until reset.
- `fetch_count`  out  16  count of accepted instructions; wraps.

## Operation
- **States:** IDLE, RUN, DRAIN, HALT.
- **Reset (async):**
  - State is IDLE and `pc` = `RESET_PC`.
  - `ir`, `ir_pc` and `fetch_count` are 0.
  - `ir_valid` and `halted` are 0.
- **IDLE:**
  - `ir_valid` is 0 and `imem_addr` = `RESET_PC`.
  - `start`=1 moves to RUN.
  - `redirect` is ignored.
- **RUN:**
  - A load happens when `ir_valid`=0 or (`ir_valid` & `ir_ready`).
  - On a load: `ir`←`imem_data`, `ir_pc`←`pc`, `pc`←`pc`+4 (mod 2^32), `ir_valid`←1.
  - Otherwise `ir`, `ir_pc`, `pc` and `ir_valid` all hold.
  - If the loaded word equals `HALT_WORD`, go to DRAIN.
- **DRAIN:**
  - No new loads; `pc` holds at the halt address + 4.
  - When `ir_valid` & `ir_ready`: `ir_valid`←0 and go to HALT.
- **HALT:**
  - `halted`=1 and `ir_valid`=0.
  - All inputs are ignored; only `reset` exits.
- **Redirect** (RUN or DRAIN) has priority over load, hold and halt detection:
  - `pc`←{`redirect_pc`[31:2],2'b00} and `ir_valid`←0, which flushes `ir`.
  - Next state is RUN, which also cancels DRAIN.
  - A handshake in the same cycle still counts; the flushed word is not re-presented.
- **`fetch_count`:** increments on every `ir_valid` & `ir_ready` cycle, including the cycle it coincides with a redirect. Wraps 16'hFFFF→0.
- **PC wrap:** 32'hFFFF_FFFC + 4 = 32'h0000_0000; no special handling.
- **`ir_ready` while `ir_valid`=0** has no effect.

## Timing
- All state and outputs are registered. `imem_addr` is driven directly from the `pc` register, with no logic between.
- **Start latency:** `start` sampled at edge N → RUN after N. First `ir_valid`=1 after edge N+1, with `ir_pc`=`RESET_PC`.
- **Throughput:** one instruction per cycle while `ir_ready`=1 continuously.
- **Redirect bubble:** `redirect` at edge M → `ir_valid`=0 after M. The target word is valid after M+1, a one-cycle bubble.
- **Halt:** the halt word is valid the cycle after it is loaded. `halted` rises on the edge where it is accepted.
- **Mid-operation reset:** asserting `reset` clears everything immediately, without waiting for a clock edge. Fetch resumes only after a new `start`.

## Test plan
The bench models memory as a word array (`mem[addr>>2]`) driving `imem_data`.
- **Basic stream:**
  - Setup: `mem[0..3]` = 32'h2001_0005, 32'h2002_0003, 32'h0022_1820, 32'hFC00_0000; `ir_ready`=1; pulse `start`.
  - Required: `ir_pc` = 0, 4, 8, 12 on consecutive cycles; then `halted`=1 and `fetch_count`=4.
- **Back-pressure:**
  - Stimulus: hold `ir_ready`=0 for 3 cycles while `ir`=32'h2002_0003.
  - Required: `ir` and `ir_pc`=4 stable and `imem_addr`=8 stable; the stream resumes with `ir_pc`=8 after release.
- **Redirect:**
  - Stimulus: pulse `redirect` with `redirect_pc`=32'h0000_0023 while `ir_pc`=4.
  - Required: next cycle `ir_valid`=0; the following cycle `ir_pc`=32'h20 and `ir`=`mem[8]`.
- **Redirect cancels drain:**
  - Stimulus: pulse `redirect`=1 (`redirect_pc`=0) while the halt word is presented and `ir_ready`=0.
  - Required: `halted` stays 0 and fetch restarts at 0.
- **Wrap:**
  - Stimulus: redirect to 32'hFFFF_FFFC.
  - Required: next accepted `ir_pc` values are 32'hFFFF_FFFC then 32'h0000_0000.
- **Async reset mid-stream:**
  - Stimulus: assert `reset` between edges while `ir_valid`=1.
  - Required: `ir_valid`, `fetch_count` and `halted` are 0 and `imem_addr`=`RESET_PC` immediately; no fetch until `start`.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, latches fetched words into an instruction
// register handed to decode via valid/ready, applies redirects and stops on a halt word.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   output logic        ir_valid,
   input  logic        ir_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic        handshake;
   logic        load;

   assign imem_addr = pc;
   assign handshake = ir_valid & ir_ready;
   assign load      = ~ir_valid | ir_ready;

   // Sequencer state, PC, instruction register and acceptance counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         ir          <= 32'h0000_0000;
         ir_pc       <= 32'h0000_0000;
         ir_valid    <= 1'b0;
         halted      <= 1'b0;
         fetch_count <= 16'h0000;
      end else begin
         // A handshake counts even when a redirect flushes in the same cycle
         if (handshake) begin
            fetch_count <= fetch_count + 16'h0001;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
               end
            end
            RUN, DRAIN: begin
               if (redirect) begin
                  pc       <= {redirect_pc[31:2], 2'b00};
                  ir_valid <= 1'b0;
                  state    <= RUN;
               end else if (state == RUN) begin
                  if (load) begin
                     ir       <= imem_data;
                     ir_pc    <= pc;
                     pc       <= pc + 32'd4;
                     ir_valid <= 1'b1;
                     if (imem_data == HALT_WORD) begin
                        state <= DRAIN;
                     end
                  end
               end else if (handshake) begin
                  // Halt word accepted by decode: stop for good
                  ir_valid <= 1'b0;
                  halted   <= 1'b1;
                  state    <= HALT;
               end
            end
            HALT: begin
               ir_valid <= 1'b0;
               halted   <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               ir_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a word-array instruction memory.
module tb_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halted;
   logic [15:0] fetch_count;

   logic [31:0] mem [64];
   int          errors;
   int          checks;

   fetch_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .ir          (ir),
      .ir_pc       (ir_pc),
      .ir_valid    (ir_valid),
      .ir_ready    (ir_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   assign imem_data = mem[imem_addr[7:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land on the following falling edge
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b1;
      #1;
      check_eq("rst_valid", {31'd0, ir_valid}, 32'd0);
      check_eq("rst_count", {16'd0, fetch_count}, 32'd0);
      check_eq("rst_halted", {31'd0, halted}, 32'd0);
      check_eq("rst_addr", imem_addr, 32'h0000_0000);
      #1 reset = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
      mem[0]  = 32'h2001_0005;
      mem[1]  = 32'h2002_0003;
      mem[2]  = 32'h0022_1820;
      mem[3]  = 32'hFC00_0000;
      mem[8]  = 32'h1234_5678;
      mem[63] = 32'hAAAA_0001;
      reset = 1'b1;
      start = 1'b0;
      ir_ready = 1'b1;
      redirect = 1'b0;
      redirect_pc = 32'h0000_0000;

      // Reset state
      @(negedge clk);
      check_eq("reset_ir", ir, 32'h0);
      check_eq("reset_ir_pc", ir_pc, 32'h0);
      check_eq("reset_valid", {31'd0, ir_valid}, 32'd0);
      check_eq("reset_halted", {31'd0, halted}, 32'd0);
      check_eq("reset_addr", imem_addr, 32'h0);
      reset = 1'b0;
      cycle();
      check_eq("idle_valid", {31'd0, ir_valid}, 32'd0);

      // Basic stream
      start = 1'b1;
      cycle();
      start = 1'b0;
      check_eq("start_lat_valid", {31'd0, ir_valid}, 32'd0);
      cycle();
      check_eq("s0_valid", {31'd0, ir_valid}, 32'd1);
      check_eq("s0_pc", ir_pc, 32'h0);
      check_eq("s0_ir", ir, 32'h2001_0005);
      cycle();
      check_eq("s1_pc", ir_pc, 32'h4);
      cycle();
      check_eq("s2_pc", ir_pc, 32'h8);
      check_eq("s2_ir", ir, 32'h0022_1820);
      cycle();
      check_eq("s3_pc", ir_pc, 32'hC);
      check_eq("s3_ir", ir, 32'hFC00_0000);
      check_eq("s3_halted", {31'd0, halted}, 32'd0);
      cycle();
      check_eq("halt_halted", {31'd0, halted}, 32'd1);
      check_eq("halt_valid", {31'd0, ir_valid}, 32'd0);
      check_eq("halt_count", {16'd0, fetch_count}, 32'd4);
      check_eq("halt_addr", imem_addr, 32'h10);
      start = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h20;
      cycle();
      start = 1'b0;
      redirect = 1'b0;
      check_eq("halt_ign_halted", {31'd0, halted}, 32'd1);
      check_eq("halt_ign_valid", {31'd0, ir_valid}, 32'd0);
      check_eq("halt_ign_addr", imem_addr, 32'h10);

      // Back-pressure
      pulse_reset();
      @(negedge clk);
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      check_eq("bp_first_pc", ir_pc, 32'h0);
      cycle();
      check_eq("bp_pc4", ir_pc, 32'h4);
      ir_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_eq("bp_hold_ir", ir, 32'h2002_0003);
         check_eq("bp_hold_pc", ir_pc, 32'h4);
         check_eq("bp_hold_addr", imem_addr, 32'h8);
         check_eq("bp_hold_valid", {31'd0, ir_valid}, 32'd1);
      end
      ir_ready = 1'b1;
      cycle();
      check_eq("bp_resume_pc", ir_pc, 32'h8);
      check_eq("bp_count", {16'd0, fetch_count}, 32'd2);

      // Redirect cancels drain
      cycle();
      check_eq("drain_ir", ir, 32'hFC00_0000);
      check_eq("drain_pc", ir_pc, 32'hC);
      ir_ready = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h0;
      cycle();
      redirect = 1'b0;
      ir_ready = 1'b1;
      check_eq("cancel_valid", {31'd0, ir_valid}, 32'd0);
      check_eq("cancel_halted", {31'd0, halted}, 32'd0);
      check_eq("cancel_addr", imem_addr, 32'h0);
      check_eq("cancel_count", {16'd0, fetch_count}, 32'd3);
      cycle();
      check_eq("restart_pc", ir_pc, 32'h0);
      check_eq("restart_valid", {31'd0, ir_valid}, 32'd1);
      check_eq("restart_halted", {31'd0, halted}, 32'd0);

      // Redirect with misaligned target while ir_pc=4
      cycle();
      check_eq("redir_pre_pc", ir_pc, 32'h4);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0023;
      cycle();
      redirect = 1'b0;
      check_eq("redir_bubble", {31'd0, ir_valid}, 32'd0);
      check_eq("redir_count", {16'd0, fetch_count}, 32'd5);
      check_eq("redir_addr", imem_addr, 32'h20);
      cycle();
      check_eq("redir_pc", ir_pc, 32'h20);
      check_eq("redir_ir", ir, 32'h1234_5678);

      // PC wrap
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      cycle();
      redirect = 1'b0;
      check_eq("wrap_bubble", {31'd0, ir_valid}, 32'd0);
      cycle();
      check_eq("wrap_pc_hi", ir_pc, 32'hFFFF_FFFC);
      check_eq("wrap_ir", ir, 32'hAAAA_0001);
      check_eq("wrap_addr", imem_addr, 32'h0);
      cycle();
      check_eq("wrap_pc_lo", ir_pc, 32'h0);
      check_eq("wrap_count", {16'd0, fetch_count}, 32'd7);

      // Async reset mid-stream
      check_eq("mid_valid_pre", {31'd0, ir_valid}, 32'd1);
      pulse_reset();
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_eq("post_rst_valid", {31'd0, ir_valid}, 32'd0);
         check_eq("post_rst_addr", imem_addr, 32'h0);
      end
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      check_eq("refetch_valid", {31'd0, ir_valid}, 32'd1);
      check_eq("refetch_pc", ir_pc, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
